// File: rtl/pb_pkg.sv
// Shared definitions for the pushbutton debouncer / priority encoder.
// Holds the press-tracking state type and the default widths.
package pb_pkg;

    localparam int KEY_W      = 5;
    localparam int NUM_PB_DEF = 21;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_RELEASE = 2'd2
    } pb_state_e;

endpackage

// File: rtl/pb_debounce_bit.sv
// One pushbutton lane: two-flop synchronizer, stability counter and debounced flop.
// db follows the synchronized level only after it has disagreed long enough.
module pb_debounce_bit
    import pb_pkg::*;
#(
    parameter int STABLE_CYCLES = 3
) (
    input  logic hz100,
    input  logic reset,
    input  logic raw,
    output logic db
);

    logic       sync1_r;
    logic       sync2_r;
    logic       db_r;
    logic [3:0] cnt_r;

    // Synchronize the raw level, then count consecutive disagreeing samples.
    always_ff @(posedge hz100) begin
        if (reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            db_r    <= 1'b0;
            cnt_r   <= 4'd0;
        end else begin
            sync1_r <= raw;
            sync2_r <= sync1_r;
            if (sync2_r == db_r) begin
                cnt_r <= 4'd0;
            end else if (cnt_r == 4'(STABLE_CYCLES)) begin
                db_r  <= sync2_r;
                cnt_r <= 4'd0;
            end else begin
                cnt_r <= cnt_r + 4'd1;
            end
        end
    end

    assign db = db_r;

endmodule

// File: rtl/pb_debounce_enc.sv
// Debounced pushbutton bank with highest-index encoder, press FSM and press counter.
// One strobe per accepted press; further buttons are ignored until all are released.
module pb_debounce_enc
    import pb_pkg::*;
#(
    parameter int STABLE_CYCLES = 3,
    parameter int NUM_PB        = NUM_PB_DEF
) (
    input  logic              hz100,
    input  logic              reset,
    input  logic [NUM_PB-1:0] pb,
    output logic [KEY_W-1:0]  keycode,
    output logic              strobe,
    output logic              held,
    output logic [7:0]        press_count,
    output logic [NUM_PB-1:0] db
);

    logic [NUM_PB-1:0] db_s;
    pb_state_e         state_r;
    pb_state_e         state_nxt_s;
    logic [KEY_W-1:0]  keycode_r;
    logic [KEY_W-1:0]  keycode_nxt_s;
    logic              strobe_r;
    logic              strobe_nxt_s;
    logic              held_r;
    logic              held_nxt_s;
    logic [7:0]        count_r;
    logic [7:0]        count_nxt_s;

    for (genvar k = 0; k < NUM_PB; k++) begin : g_bit
        pb_debounce_bit #(
            .STABLE_CYCLES(STABLE_CYCLES)
        ) u_bit (
            .hz100(hz100),
            .reset(reset),
            .raw  (pb[k]),
            .db   (db_s[k])
        );
    end

    // Later (higher) indices overwrite earlier ones, so the highest set bit wins.
    function automatic logic [KEY_W-1:0] top_index(input logic [NUM_PB-1:0] v);
        logic [KEY_W-1:0] idx;
        idx = {KEY_W{1'b0}};
        for (int i = 0; i < NUM_PB; i++) begin
            idx = v[i] ? KEY_W'(i) : idx;
        end
        return idx;
    endfunction

    // Next-state and next-output logic for press acceptance.
    always_comb begin
        state_nxt_s   = state_r;
        keycode_nxt_s = keycode_r;
        strobe_nxt_s  = 1'b0;
        count_nxt_s   = count_r;
        case (state_r)
            ST_IDLE: begin
                if (db_s != {NUM_PB{1'b0}}) begin
                    state_nxt_s   = ST_PRESSED;
                    keycode_nxt_s = top_index(db_s);
                    strobe_nxt_s  = 1'b1;
                    count_nxt_s   = count_r + 8'd1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_PRESSED: begin
                if (db_s == {NUM_PB{1'b0}}) begin
                    state_nxt_s = ST_RELEASE;
                end else begin
                    state_nxt_s = ST_PRESSED;
                end
            end
            ST_RELEASE: state_nxt_s = ST_IDLE;
            default:    state_nxt_s = ST_IDLE;
        endcase
        held_nxt_s = (state_nxt_s == ST_PRESSED);
    end

    // State and registered outputs.
    always_ff @(posedge hz100) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            keycode_r <= {KEY_W{1'b0}};
            strobe_r  <= 1'b0;
            held_r    <= 1'b0;
            count_r   <= 8'd0;
        end else begin
            state_r   <= state_nxt_s;
            keycode_r <= keycode_nxt_s;
            strobe_r  <= strobe_nxt_s;
            held_r    <= held_nxt_s;
            count_r   <= count_nxt_s;
        end
    end

    assign keycode     = keycode_r;
    assign strobe      = strobe_r;
    assign held        = held_r;
    assign press_count = count_r;
    assign db          = db_s;

endmodule

// File: doc/pb_debounce_enc.md
PB_DEBOUNCE_ENC -- requirements
Module: pb_debounce_enc

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 3, meaning consecutive hz100 samples a synchronized bit must differ before its debounced value changes (legal range 1..15).
REQ-002 SHALL have parameter NUM_PB, default 21, meaning number of pushbutton inputs.
REQ-003 SHALL have port hz100 input 1: sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset input 1: reset is synchronous and active-high.
REQ-005 SHALL have port pb input NUM_PB: raw asynchronous pushbutton levels, 1 = pressed.
REQ-006 SHALL have port keycode output 5: index of the accepted button.
REQ-007 SHALL have port strobe output 1: one-cycle pulse per accepted press.
REQ-008 SHALL have port held output 1: high while the accepted press is still down.
REQ-009 SHALL have port press_count output 8: number of accepted presses, modulo 256.
REQ-010 SHALL have port db output NUM_PB: debounced button vector.

Function
REQ-011 SHALL pass each pb bit through a two-flop synchronizer before any other use.
REQ-012 SHALL keep, per bit, a 4-bit counter that clears whenever the synchronized value equals db[k] and otherwise increments; when it reaches STABLE_CYCLES, db[k] takes the synchronized value and the counter clears.
REQ-013 SHALL implement FSM states IDLE, PRESSED, RELEASE.
REQ-014 IDLE -> PRESSED when db is nonzero: keycode loads the highest-index set bit of db, strobe is high for exactly the next cycle, press_count increments.
REQ-015 PRESSED: held = 1; keycode frozen; new bits rising in db SHALL NOT produce a strobe nor change keycode.
REQ-016 PRESSED -> RELEASE when db is all zero; RELEASE -> IDLE on the next edge (one guaranteed dead cycle, held = 0).
REQ-017 If db becomes nonzero again during RELEASE, the FSM SHALL still enter IDLE first; the press is accepted from IDLE on the following edge.
REQ-018 Latency: a clean press on pb[k] first sampled at edge 0 SHALL give strobe high during the cycle after edge 3+STABLE_CYCLES (edge 6 at default).
REQ-019 A pulse on pb shorter than STABLE_CYCLES synchronized samples SHALL NOT change db or generate a strobe.
REQ-020 Simultaneous press of several buttons, debounced on the same edge: highest index wins.
REQ-021 press_count SHALL wrap from 255 to 0 without other side effect.
REQ-022 keycode SHALL hold its last value through RELEASE and IDLE until the next accepted press.

Reset
REQ-023 While reset is high at an edge: synchronizers, counters and db SHALL clear to 0, FSM to IDLE, keycode 0, strobe 0, held 0, press_count 0.
REQ-024 Reset mid-press SHALL abort the press with no strobe; a button still held after reset deasserts SHALL be re-debounced and accepted as a new press.

Structure
REQ-025 Package pb_pkg SHALL hold the FSM state enum, KEY_W = 5 and the NUM_PB default.
REQ-026 One sub-module pb_debounce_bit (synchronizer + counter + db flop for one bit) SHALL be instantiated NUM_PB times.
REQ-027 The encoder, FSM and press counter SHALL reside in pb_debounce_enc.

Verification
REQ-028 Reset, then pb[5] = 1 held 10 cycles -> strobe high exactly once at cycle 6, keycode = 5, held = 1, press_count = 1.
REQ-029 pb[3] high for 2 cycles only -> db stays 0, no strobe, press_count unchanged.
REQ-030 pb[2] and pb[17] rise together -> single strobe, keycode = 17; later pb[9] added while held -> no strobe, keycode stays 17.
REQ-031 Release all, re-press pb[0] -> held drops, one RELEASE cycle, then new strobe with keycode = 0, press_count incremented.
REQ-032 256 clean presses of pb[1] -> press_count returns to 0 after the last.
REQ-033 pb[20] held, reset asserted 1 cycle at cycle 4 -> no strobe before reset; strobe 6 cycles after reset deasserts, keycode = 20, press_count = 1.
